// File: rtl/segment_display_scanner_pkg.sv
// segment_display_scanner_pkg: shared sizes, FSM states and inactive output levels.
// Provides NUM_DIGITS/SEG_W/IDX_W, the IDLE/SCAN state type and helpers that
// return the unlit/deselected level of each output for a given polarity.
package segment_display_scanner_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W = 7;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [0:SEG_W-1] seg_off(input bit active_low);
        return {SEG_W{active_low}};
    endfunction

    function automatic logic dot_off(input bit active_low);
        return active_low;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_off(input bit active_low);
        return {NUM_DIGITS{active_low}};
    endfunction
endpackage

// File: rtl/segment_display_scanner_digit_mux.sv
// segment_digit_mux: 4:1 select of {digit vector, dot} plus one-hot anode decode.
// Ports:
//   Digit0_i..Digit3_i  segment vectors, active-high lit
//   DotMask_i           decimal point per digit, bit n = digit n
//   Sel_i               digit index to select
//   Seg_o / Dot_o       selected vector and dot, active-high
//   Anode_o             one-hot of Sel_i, active-high
module segment_digit_mux
    import segment_display_scanner_pkg::*;
(
    input  logic [0:SEG_W-1]      Digit0_i,
    input  logic [0:SEG_W-1]      Digit1_i,
    input  logic [0:SEG_W-1]      Digit2_i,
    input  logic [0:SEG_W-1]      Digit3_i,
    input  logic [NUM_DIGITS-1:0] DotMask_i,
    input  logic [IDX_W-1:0]      Sel_i,
    output logic [0:SEG_W-1]      Seg_o,
    output logic                  Dot_o,
    output logic [NUM_DIGITS-1:0] Anode_o
);
    always_comb begin
        Seg_o   = Sel_i[1] ? (Sel_i[0] ? Digit3_i : Digit2_i) : (Sel_i[0] ? Digit1_i : Digit0_i);
        Dot_o   = DotMask_i[Sel_i];
        Anode_o = NUM_DIGITS'(1) << Sel_i;
    end
endmodule

// File: rtl/segment_display_scanner.sv
// segment_display_scanner: time-multiplexes four 7-segment digits onto one bus with per-digit PWM.
// Ports:
//   Clk_i          system clock, posedge
//   Reset_i        synchronous active-high reset, overrides every other input
//   ClkEnable_i    scan tick, one Clk wide
//   Enable_i       0 = display dark and scanner idle
//   Digit0_i..3_i  segment vectors [0:6], active-high lit
//   DotMask_i      decimal point per digit
//   Brightness_i   lit ticks per slot, clamped to SLOT_TICKS
//   Segments_o     shared segment bus, polarity per SEG_ACTIVE_LOW
//   Dot_o          shared decimal point, same polarity as Segments_o
//   Anodes_o       digit strobes, one-hot when lit, polarity per ANODE_ACTIVE_LOW
//   DigitIndex_o   digit index of the slot being shown
//   FrameDone_o    one-Clk pulse when the digit-3 slot completes
// Build option: SEGMENT_SCANNER_BLANKING_EN keeps the first BLANK_TICKS ticks
// of every slot dark to avoid ghosting; undefined, BLANK_TICKS is ignored.
module segment_display_scanner
    import segment_display_scanner_pkg::*;
#(
    parameter int SLOT_TICKS       = 8,
    parameter int CNT_W            = 4,
    parameter int BLANK_TICKS      = 1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  ClkEnable_i,
    input  logic                  Enable_i,
    input  logic [0:SEG_W-1]      Digit0_i,
    input  logic [0:SEG_W-1]      Digit1_i,
    input  logic [0:SEG_W-1]      Digit2_i,
    input  logic [0:SEG_W-1]      Digit3_i,
    input  logic [NUM_DIGITS-1:0] DotMask_i,
    input  logic [CNT_W-1:0]      Brightness_i,
    output logic [0:SEG_W-1]      Segments_o,
    output logic                  Dot_o,
    output logic [NUM_DIGITS-1:0] Anodes_o,
    output logic [IDX_W-1:0]      DigitIndex_o,
    output logic                  FrameDone_o
);
    localparam logic [CNT_W-1:0] SLOT_N   = CNT_W'(SLOT_TICKS);
    localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(SLOT_TICKS - 1);
`ifdef SEGMENT_SCANNER_BLANKING_EN
    localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_TICKS);
`endif

    if (SLOT_TICKS < 2 || (1 << CNT_W) <= SLOT_TICKS || BLANK_TICKS < 0) begin : g_bad_params
        $error("segment_display_scanner: illegal SLOT_TICKS/CNT_W/BLANK_TICKS");
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [0:SEG_W-1]      seg_lat_q, seg_lat_d, mux_seg;
    logic                  dot_lat_q, dot_lat_d, mux_dot;
    logic [NUM_DIGITS-1:0] an_lat_q, an_lat_d, mux_an;
    logic [CNT_W-1:0]      bright;
    logic                  scan, start, last_tick, wrap, lit;

    // The mux looks at the index of the slot about to begin, so the latch
    // captures that digit (and its one-hot anode) on the edge the slot starts.
    segment_digit_mux u_mux (
        .Digit0_i  (Digit0_i),
        .Digit1_i  (Digit1_i),
        .Digit2_i  (Digit2_i),
        .Digit3_i  (Digit3_i),
        .DotMask_i (DotMask_i),
        .Sel_i     (idx_d),
        .Seg_o     (mux_seg),
        .Dot_o     (mux_dot),
        .Anode_o   (mux_an)
    );

    always_comb begin
        scan      = state_q == SCAN && Enable_i;
        start     = state_q == IDLE && Enable_i;
        last_tick = tick_q == SLOT_MAX;
        wrap      = scan && ClkEnable_i && last_tick;
        bright    = Brightness_i > SLOT_N ? SLOT_N : Brightness_i;
`ifdef SEGMENT_SCANNER_BLANKING_EN
        lit       = scan && tick_q >= BLANK && tick_q < bright;
`else
        lit       = scan && tick_q < bright;
`endif
        state_d   = Enable_i ? SCAN : IDLE;
        tick_d    = !scan ? '0 : ClkEnable_i ? (last_tick ? '0 : tick_q + 1'b1) : tick_q;
        idx_d     = !scan ? '0 : wrap ? idx_q + 1'b1 : idx_q;
        {an_lat_d, seg_lat_d, dot_lat_d} = (start || wrap) ? {mux_an, mux_seg, mux_dot}
                                                           : {an_lat_q, seg_lat_q, dot_lat_q};
    end

    // Outputs are computed from the pre-edge slot state, gated by Enable_i so
    // dropping Enable darkens the display on the very next edge.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            idx_q        <= '0;
            seg_lat_q    <= '0;
            dot_lat_q    <= 1'b0;
            an_lat_q     <= '0;
            Segments_o   <= seg_off(SEG_ACTIVE_LOW);
            Dot_o        <= dot_off(SEG_ACTIVE_LOW);
            Anodes_o     <= anode_off(ANODE_ACTIVE_LOW);
            DigitIndex_o <= '0;
            FrameDone_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            seg_lat_q    <= seg_lat_d;
            dot_lat_q    <= dot_lat_d;
            an_lat_q     <= an_lat_d;
            Segments_o   <= lit ? seg_lat_q ^ seg_off(SEG_ACTIVE_LOW) : seg_off(SEG_ACTIVE_LOW);
            Dot_o        <= lit ? dot_lat_q ^ dot_off(SEG_ACTIVE_LOW) : dot_off(SEG_ACTIVE_LOW);
            Anodes_o     <= lit ? an_lat_q ^ anode_off(ANODE_ACTIVE_LOW) : anode_off(ANODE_ACTIVE_LOW);
            DigitIndex_o <= scan ? idx_q : '0;
            FrameDone_o  <= wrap && idx_q == IDX_W'(NUM_DIGITS - 1);
        end
    end
endmodule
